bt656_dec: RTL and testbench

Recovers BT.601 timing from an embedded-sync BT.656 byte stream on the 27 MHz video clock. Detects EAV/SAV timing-reference codes (FF 00 00 XY), checks the XY protection bits, and emits pixel data with aligned H/V/F flags. Also reports line-length lock. It sits directly upstream of the video input line-store stage (vin_pro). Its dout/Ho/Vo/Fo outputs drive that stage's data_in/Hi/Vi/Fi.

---
 rtl/bt656_dec.sv | 199 +++++++++++++++++++
 tb/tb_bt656_dec.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bt656_dec.sv
// BT.656 embedded-sync decoder: finds EAV/SAV timing codes, checks XY protection,
// and re-times H/V/F flags onto a fixed 4-clk data pipeline with line-length lock.
module bt656_dec #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 12,
  parameter int LOCK_LINES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             Ho,
  output logic             Vo,
  output logic             Fo,
  output logic             eav_p,
  output logic             sav_p,
  output logic             prot_err,
  output logic             locked,
  output logic [LEN_W-1:0] line_len
);

  localparam int              MW       = $clog2(LOCK_LINES + 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_LINES);
  localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};

  function automatic logic [3:0] prot_bits(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Stage 0 is the byte one clk behind din; stage 2 feeds the output register.
  logic [WIDTH-1:0] pd_q [3];
  logic [WIDTH-1:0] pd_d [3];
  logic [2:0]       ph_q, ph_d, pv_q, pv_d, pf_q, pf_d;
  logic [2:0]       pc_q, pc_d, pe_q, pe_d, ps_q, ps_d;

  logic             h_q, h_d, v_q, v_d, f_q, f_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ho_q, ho_d, vo_q, vo_d, fo_q, fo_d;
  logic             eav_q, eav_d, sav_q, sav_d;
  logic             prot_q, prot_d;

  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [LEN_W-1:0] cnt_inc_s;
  logic [MW-1:0]    match_q, match_d;
  logic             locked_q, locked_d;

  logic [7:0] b0_s, b1_s, b2_s, b3_s;
  logic       xy_f_s, xy_v_s, xy_h_s;
  logic       code_s, prot_ok_s, valid_s, eav_in_s;

  assign b0_s = din[WIDTH-1 -: 8];
  assign b1_s = pd_q[0][WIDTH-1 -: 8];
  assign b2_s = pd_q[1][WIDTH-1 -: 8];
  assign b3_s = pd_q[2][WIDTH-1 -: 8];

  assign xy_f_s    = b0_s[6];
  assign xy_v_s    = b0_s[5];
  assign xy_h_s    = b0_s[4];
  assign code_s    = (b3_s == 8'hFF) && (b2_s == 8'h00) && (b1_s == 8'h00) && b0_s[7];
  assign prot_ok_s = (b0_s[3:0] == prot_bits(xy_f_s, xy_v_s, xy_h_s));
  assign valid_s   = code_s && prot_ok_s;
  assign eav_in_s  = valid_s && xy_h_s;

  // Pipeline shift; a valid code retags the three preamble bytes already in flight.
  always_comb begin
    pd_d[0] = din;
    pd_d[1] = pd_q[0];
    pd_d[2] = pd_q[1];
    ph_d    = {ph_q[1:0], h_q};
    pv_d    = {pv_q[1:0], v_q};
    pf_d    = {pf_q[1:0], f_q};
    pc_d    = {pc_q[1:0], 1'b0};
    pe_d    = {pe_q[1:0], 1'b0};
    ps_d    = {ps_q[1:0], 1'b0};
    dout_d  = pd_q[2];
    ho_d    = ph_q[2] | pc_q[2];
    vo_d    = pv_q[2];
    fo_d    = pf_q[2];
    eav_d   = pe_q[2];
    sav_d   = ps_q[2];
    h_d     = h_q;
    v_d     = v_q;
    f_d     = f_q;
    prot_d  = code_s && !prot_ok_s;
    if (valid_s) begin
      h_d   = xy_h_s;
      v_d   = xy_v_s;
      f_d   = xy_f_s;
      ph_d  = {3{xy_h_s}};
      pv_d  = {3{xy_v_s}};
      pf_d  = {3{xy_f_s}};
      pc_d  = 3'b111;
      pe_d  = {2'b00, xy_h_s};
      ps_d  = {2'b00, ~xy_h_s};
      ho_d  = 1'b1;
      vo_d  = xy_v_s;
      fo_d  = xy_f_s;
      eav_d = 1'b0;
      sav_d = 1'b0;
    end else begin
      h_d   = h_q;
      v_d   = v_q;
      f_d   = f_q;
    end
  end

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_W'(1);

  // Line-length measurement and lock tracking.
  always_comb begin
    cnt_d   = cnt_inc_s;
    match_d = match_q;
    len_d   = len_q;
    if (eav_in_s) begin
      cnt_d = {LEN_W{1'b0}};
      if (cnt_inc_s == len_q) begin
        if (match_q != LOCK_MAX) begin
          match_d = match_q + MW'(1);
        end else begin
          match_d = match_q;
        end
      end else begin
        match_d = {MW{1'b0}};
        len_d   = cnt_inc_s;
      end
    end else if (cnt_inc_s == CNT_MAX) begin
      match_d = {MW{1'b0}};
    end else begin
      match_d = match_q;
    end
  end

  // Unequal lines and timeouts clear match_d, so lock follows it directly.
  assign locked_d = (match_d == LOCK_MAX);

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_q[0]  <= {WIDTH{1'b0}};
      pd_q[1]  <= {WIDTH{1'b0}};
      pd_q[2]  <= {WIDTH{1'b0}};
      ph_q     <= 3'b111;
      pv_q     <= 3'b111;
      pf_q     <= 3'b000;
      pc_q     <= 3'b000;
      pe_q     <= 3'b000;
      ps_q     <= 3'b000;
      h_q      <= 1'b1;
      v_q      <= 1'b1;
      f_q      <= 1'b0;
      dout_q   <= {WIDTH{1'b0}};
      ho_q     <= 1'b1;
      vo_q     <= 1'b1;
      fo_q     <= 1'b0;
      eav_q    <= 1'b0;
      sav_q    <= 1'b0;
      prot_q   <= 1'b0;
      cnt_q    <= {LEN_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      match_q  <= {MW{1'b0}};
      locked_q <= 1'b0;
    end else begin
      pd_q[0]  <= pd_d[0];
      pd_q[1]  <= pd_d[1];
      pd_q[2]  <= pd_d[2];
      ph_q     <= ph_d;
      pv_q     <= pv_d;
      pf_q     <= pf_d;
      pc_q     <= pc_d;
      pe_q     <= pe_d;
      ps_q     <= ps_d;
      h_q      <= h_d;
      v_q      <= v_d;
      f_q      <= f_d;
      dout_q   <= dout_d;
      ho_q     <= ho_d;
      vo_q     <= vo_d;
      fo_q     <= fo_d;
      eav_q    <= eav_d;
      sav_q    <= sav_d;
      prot_q   <= prot_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      match_q  <= match_d;
      locked_q <= locked_d;
    end
  end

  assign dout     = dout_q;
  assign Ho       = ho_q;
  assign Vo       = vo_q;
  assign Fo       = fo_q;
  assign eav_p    = eav_q;
  assign sav_p    = sav_q;
  assign prot_err = prot_q;
  assign locked   = locked_q;
  assign line_len = len_q;

endmodule

// File: tb/tb_bt656_dec.sv
// Scoreboard bench for bt656_dec: per-byte expectations are queued as stimulus is
// driven and compared 4 clk later; lock/prot_err checks are scheduled by input index.
module tb_bt656_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        Ho, Vo, Fo, eav_p, sav_p, prot_err, locked;
  logic [11:0] line_len;

  always #5 clk = ~clk;

  bt656_dec #(.WIDTH(8), .LEN_W(12), .LOCK_LINES(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .Ho(Ho), .Vo(Vo), .Fo(Fo),
    .eav_p(eav_p), .sav_p(sav_p), .prot_err(prot_err), .locked(locked),
    .line_len(line_len)
  );

  typedef struct packed {
    logic [7:0] d;
    logic h, v, f, e, s;
  } exp_t;

  typedef struct {
    int          due;
    logic        prot;
    logic        lock_chk;
    logic        lock;
    logic        len_chk;
    logic [11:0] len;
  } side_t;

  exp_t  sb[$];
  side_t sq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  logic  cur_h = 1'b1, cur_v = 1'b1, cur_f = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic h, input logic v,
                              input logic f, input logic e, input logic s);
    return {d, h, v, f, e, s};
  endfunction

  task automatic add_side(input int due, input logic prot, input logic lock_chk,
                          input logic lock, input logic len_chk, input logic [11:0] len);
    side_t s;
    s.due = due; s.prot = prot; s.lock_chk = lock_chk;
    s.lock = lock; s.len_chk = len_chk; s.len = len;
    sq.push_back(s);
  endtask

  task automatic drive(input logic [7:0] b, input exp_t e);
    @(posedge clk);
    #1;
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      side_t s;
      s = sq.pop_front();
      check_eq("prot_err", 32'(prot_err), 32'(s.prot));
      if (s.lock_chk) check_eq("locked", 32'(locked), 32'(s.lock));
      if (s.len_chk) check_eq("line_len", 32'(line_len), 32'(s.len));
    end
    din = b;
    sb.push_back(e);
    cyc++;
  endtask

  // kind 0: blanking filler (80/10), kind 1: active ramp from 10
  task automatic fill(input int n, input int kind);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (kind == 0) b = (i % 2 == 0) ? 8'h80 : 8'h10;
      else           b = 8'h10 + 8'(i % 64);
      drive(b, mk(b, cur_h, cur_v, cur_f, 1'b0, 1'b0));
    end
  endtask

  task automatic send_code(input logic [7:0] xy, output int xy_idx);
    logic f, v, h, valid;
    f = xy[6]; v = xy[5]; h = xy[4];
    valid = xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    if (valid) begin
      drive(8'hFF, mk(8'hFF, 1'b1, v, f, 1'b0, 1'b0));
      drive(8'h00, mk(8'h00, 1'b1, v, f, 1'b0, 1'b0));
      drive(8'h00, mk(8'h00, 1'b1, v, f, 1'b0, 1'b0));
      xy_idx = cyc;
      drive(xy, mk(xy, 1'b1, v, f, h, ~h));
      cur_h = h; cur_v = v; cur_f = f;
      add_side(xy_idx + 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    end else begin
      drive(8'hFF, mk(8'hFF, cur_h, cur_v, cur_f, 1'b0, 1'b0));
      drive(8'h00, mk(8'h00, cur_h, cur_v, cur_f, 1'b0, 1'b0));
      drive(8'h00, mk(8'h00, cur_h, cur_v, cur_f, 1'b0, 1'b0));
      xy_idx = cyc;
      drive(xy, mk(xy, cur_h, cur_v, cur_f, 1'b0, 1'b0));
      add_side(xy_idx + 1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      add_side(xy_idx + 2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    end
  endtask

  task automatic send_line(input int nblank, input int nact, input bit do_chk,
                           input logic e_lock, input logic [11:0] e_len, output int eav_idx);
    int sav_idx;
    send_code(8'h9D, eav_idx);
    if (do_chk) add_side(eav_idx + 1, 1'b0, 1'b1, e_lock, 1'b1, e_len);
    fill(nblank, 0);
    send_code(8'h80, sav_idx);
    fill(nact, 1);
  endtask

  // Pipeline output comparison against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("dout", 32'(dout), 32'(e.d));
      check_eq("flags_HVFes", 32'({Ho, Vo, Fo, eav_p, sav_p}), 32'({e.h, e.v, e.f, e.e, e.s}));
    end
  end

  initial begin
    int xy;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("rst_hold", 32'({dout, Ho, Vo, Fo, locked, eav_p, sav_p, prot_err, line_len}),
               32'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
      din = (i % 2 == 0) ? 8'hFF : 8'h00;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    din = 8'h00;
    for (int i = 0; i < 4; i++) sb.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    cyc = 1;
    mon_en = 1'b1;

    fill(8, 0);
    // active line
    send_code(8'h80, xy);
    fill(1440, 1);
    send_code(8'h9D, xy);
    fill(40, 0);
    // protection error in the active region
    send_code(8'h80, xy);
    fill(10, 1);
    send_code(8'h81, xy);
    fill(10, 1);
    send_code(8'h9D, xy);
    fill(20, 0);
    // field / vertical flags
    send_code(8'hAB, xy);
    fill(20, 1);
    send_code(8'hC7, xy);
    fill(20, 1);
    send_code(8'hDA, xy);
    fill(20, 0);
    // lock acquisition, loss on a short line, re-lock
    send_line(268, 1440, 1'b0, 1'b0, 12'd0, xy);
    send_line(268, 1440, 1'b1, 1'b0, 12'd1716, xy);
    send_line(268, 1440, 1'b1, 1'b0, 12'd1716, xy);
    send_line(268, 1440, 1'b1, 1'b0, 12'd1716, xy);
    send_line(268, 1440, 1'b1, 1'b0, 12'd1716, xy);
    send_line(267, 1440, 1'b1, 1'b1, 12'd1716, xy);
    send_line(267, 1440, 1'b1, 1'b0, 12'd1715, xy);
    send_line(267, 1440, 1'b1, 1'b0, 12'd1715, xy);
    send_line(267, 1440, 1'b1, 1'b0, 12'd1715, xy);
    send_line(267, 1440, 1'b1, 1'b0, 12'd1715, xy);
    send_line(267, 1440, 1'b1, 1'b1, 12'd1715, xy);
    // timeout with no further codes
    add_side(xy + 4095, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    add_side(xy + 4096, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1715);
    fill(2500, 1);
    // mid-line reset
    send_code(8'h80, xy);
    fill(20, 1);
    repeat (5) @(negedge clk);
    #1;
    mon_en = 1'b0;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    check_eq("side_drain", 32'(sq.size()), 32'd0);
    check_eq("pre_rst", 32'({Ho, line_len}), 32'({1'b0, 12'd1715}));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'({dout, Ho, Vo, Fo, locked, eav_p, sav_p, prot_err, line_len}),
             32'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
    #10;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
